// File: rtl/control_acceso_pkg.sv
// control_acceso_pkg: state encoding and default parameters for the
// parametrised parking-gate access controller.
package control_acceso_pkg;

    typedef enum logic [2:0] {
        INICIO       = 3'd0,
        ESPERA_CLAVE = 3'd1,
        ABIERTA      = 3'd2,
        ALARMA_PIN   = 3'd3,
        BLOQUEO      = 3'd4
    } estado_t;

    localparam int          CLAVE_W_DEF        = 16;
    localparam logic [15:0] CLAVE_CORRECTA_DEF = 16'h1234;
    localparam int          MAX_INTENTOS_DEF   = 3;
    localparam int          TIMEOUT_DEF        = 64;

endpackage

// File: rtl/control_acceso_param_temporizador.sv
// temporizador_paso: counts cycles while habilitar is high and flags the
// TIMEOUT_CICLOS-th one. Clears whenever habilitar drops.
module temporizador_paso #(
    parameter int TIMEOUT_CICLOS = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic habilitar,
    output logic expirado
);
    localparam int             TW     = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0]  ULTIMO = TW'(TIMEOUT_CICLOS - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Count while enabled, hold at the last value, clear when disabled
    always_comb begin
        cnt_d = cnt_q;
        if (!habilitar)
            cnt_d = '0;
        else if (cnt_q != ULTIMO)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expirado = habilitar && (cnt_q == ULTIMO);

endmodule

// File: rtl/control_acceso_param.sv
// control_acceso_param: single-lane Moore FSM for a parking gate.
// PIN validation with wrong-attempt limit, tailgate lockout, and optional
// pass-through timeout enabled by defining CONTROL_ACCESO_TIMEOUT_EN.
module control_acceso_param
    import control_acceso_pkg::*;
#(
    parameter int                 CLAVE_W        = CLAVE_W_DEF,
    parameter logic [CLAVE_W-1:0] CLAVE_CORRECTA = CLAVE_CORRECTA_DEF,
    parameter int                 MAX_INTENTOS   = MAX_INTENTOS_DEF,
    parameter int                 TIMEOUT_CICLOS = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               llegado_vehiculo,
    input  logic               paso_vehiculo,
    input  logic [CLAVE_W-1:0] clave_ingresada,
    input  logic               clave_valida,
    input  logic               boton_reset,
    output logic               abriendo_compuerta,
    output logic               cerrando_compuerta,
    output logic               alarm_pin_incorrecto,
    output logic               alarm_bloqueo
);
    localparam int            IW    = $clog2(MAX_INTENTOS + 1);
    localparam logic [IW-1:0] MAX_I = IW'(MAX_INTENTOS);

    estado_t       estado_q, estado_d;
    logic [IW-1:0] intentos_q, intentos_d, intentos_inc;
    logic          cerrar_q, cerrar_d;
    logic          clave_ok, clave_mal, expirado;

    assign clave_ok     = clave_valida && (clave_ingresada == CLAVE_CORRECTA);
    assign clave_mal    = clave_valida && (clave_ingresada != CLAVE_CORRECTA);
    assign intentos_inc = (intentos_q == MAX_I) ? intentos_q : intentos_q + 1'b1;

`ifdef CONTROL_ACCESO_TIMEOUT_EN
    temporizador_paso #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_temporizador (
        .clk       (clk),
        .reset     (reset),
        .habilitar (estado_q == ABIERTA),
        .expirado  (expirado)
    );
`else
    assign expirado = 1'b0;
`endif

    // Next-state, attempt counter and close-pulse request
    always_comb begin
        estado_d   = estado_q;
        intentos_d = intentos_q;
        cerrar_d   = 1'b0;
        case (estado_q)
            INICIO: begin
                if (llegado_vehiculo) estado_d = ESPERA_CLAVE;
            end
            ESPERA_CLAVE: begin
                if (clave_ok) begin
                    estado_d   = ABIERTA;
                    intentos_d = '0;
                end else if (clave_mal) begin
                    intentos_d = intentos_inc;
                    if (intentos_inc == MAX_I) estado_d = ALARMA_PIN;
                end
            end
            ALARMA_PIN: begin
                if (clave_ok) begin
                    estado_d   = ABIERTA;
                    intentos_d = '0;
                end
            end
            ABIERTA: begin
                // A pass wins over the timeout; tailgating wins over both
                if (paso_vehiculo && llegado_vehiculo) begin
                    estado_d = BLOQUEO;
                end else if (paso_vehiculo || expirado) begin
                    estado_d = INICIO;
                    cerrar_d = 1'b1;
                end
            end
            BLOQUEO: begin
                if (boton_reset && clave_ok) begin
                    estado_d   = INICIO;
                    intentos_d = '0;
                end
            end
            default: estado_d = INICIO;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= INICIO;
            intentos_q <= '0;
            cerrar_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            intentos_q <= intentos_d;
            cerrar_q   <= cerrar_d;
        end
    end

    // Moore output decode from registered state and close-pulse flag
    always_comb begin
        abriendo_compuerta   = (estado_q == ABIERTA);
        cerrando_compuerta   = cerrar_q || (estado_q == BLOQUEO);
        alarm_pin_incorrecto = (estado_q == ALARMA_PIN);
        alarm_bloqueo        = (estado_q == BLOQUEO);
    end

endmodule
